// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring integer divider (DIV/DIVU) producing {remainder, quotient} for HI/LO.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start_i, signed_i       divide request (held until done_o) and signed mode
//   dividend_i, divisor_i   operands, sampled with start_i in IDLE
//   flush_i                 exception flush, aborts any operation
//   stallreq_o              stall request while start_i is high and the result is not yet strobed
//   busy_o, done_o          calculating / one-cycle result strobe
//   div_zero_o              divisor was zero, valid with done_o
//   hilo_o                  {remainder, quotient}, held until the next result
module div_unit #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    input  logic                 flush_i,
    output logic                 stallreq_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 div_zero_o,
    output logic [2*WIDTH-1:0]   hilo_o
);
    localparam int ITERS = WIDTH / STEP_BITS;
    localparam int CW    = $clog2(ITERS);
    typedef enum logic [1:0] {IDLE, CALC, FIXSIGN, DONE} state_t;
    state_t             state_q, state_d;
    logic [WIDTH:0]     rem_q, rem_d, rem_s;
    logic [WIDTH-1:0]   quo_q, quo_d, quo_s;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [2*WIDTH-1:0] hilo_q, hilo_d;
    // quo_q starts as the dividend magnitude and is shifted out MSB first while quotient bits shift in
    always_comb begin
        rem_s = rem_q;
        quo_s = quo_q;
        for (int i = 0; i < STEP_BITS; i++) begin
            rem_s = {rem_s[WIDTH-1:0], quo_s[WIDTH-1]};
            quo_s = {quo_s[WIDTH-2:0], 1'b0};
            if (rem_s >= {1'b0, dsr_q}) begin
                rem_s    = rem_s - {1'b0, dsr_q};
                quo_s[0] = 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hilo_d  = hilo_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    quo_d   = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
                    dsr_d   = (signed_i && divisor_i[WIDTH-1]) ? -divisor_i : divisor_i;
                    rem_d   = '0;
                    cnt_d   = '0;
                    qneg_d  = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                    rneg_d  = signed_i & dividend_i[WIDTH-1];
                    dz_d    = (divisor_i == '0);
                    state_d = dz_d ? DONE : CALC;
                    hilo_d  = dz_d ? {dividend_i, {WIDTH{1'b1}}} : hilo_q;
                end
                CALC: begin
                    rem_d   = rem_s;
                    quo_d   = quo_s;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CW'(ITERS - 1)) ? FIXSIGN : CALC;
                end
                FIXSIGN: begin
                    hilo_d  = {rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0],
                               qneg_q ? -quo_q : quo_q};
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hilo_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hilo_q  <= hilo_d;
        end
    end
    assign stallreq_o = start_i && (state_q != DONE);
    assign busy_o     = (state_q == CALC) || (state_q == FIXSIGN);
    assign done_o     = (state_q == DONE);
    assign div_zero_o = dz_q;
    assign hilo_o     = hilo_q;
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised multi-cycle integer divider for the execute stage; serves DIV/DIVU and replaces single-cycle divide paths.
- Produces a {remainder, quotient} pair in HI/LO order for the HILO write path.
- Drives a stall request to the stall control unit while busy.
- Abandons work on exception flush.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.
- STEP_BITS, 1, quotient bits resolved per cycle (1 or 2); WIDTH must be divisible by STEP_BITS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  divide request; held high by execute stage until done_o seen
- signed_i  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start_i in IDLE
- dividend_i  in  WIDTH  dividend; sampled with start_i in IDLE
- divisor_i  in  WIDTH  divisor; sampled with start_i in IDLE
- flush_i  in  1  exception flush; aborts operation
- stallreq_o  out  1  combinational: start_i high and state not DONE
- busy_o  out  1  high in CALC and FIXSIGN
- done_o  out  1  one-cycle result-valid strobe (state DONE)
- div_zero_o  out  1  divisor was zero; valid with done_o
- hilo_o  out  2*WIDTH  {remainder, quotient}; held until next operation starts

Behaviour:
- Reset: async, rst_n low forces state IDLE; busy_o, done_o, div_zero_o = 0; hilo_o = 0; internal registers cleared.
- States: IDLE, CALC, FIXSIGN, DONE.
- IDLE, start_i=1, flush_i=0: latch operands and sign mode.
  - Latch magnitudes: absolute values if signed_i, else raw values.
  - Latch result signs: qneg = sign(dividend) ^ sign(divisor); rneg = sign(dividend).
  - If divisor_i == 0, go to DONE.
  - Otherwise clear the iteration counter and go to CALC.
- CALC: restoring shift-subtract, STEP_BITS quotient bits per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits.
  - Stay for WIDTH/STEP_BITS cycles, then go to FIXSIGN.
- FIXSIGN: negate quotient if qneg; negate remainder if rneg (signed only). Then go to DONE.
- DONE: done_o = 1 for exactly one cycle; return to IDLE unconditionally.
- Latency: start sampled at edge 0 gives done_o high in cycle WIDTH/STEP_BITS + 2 (34 for WIDTH=32, STEP_BITS=1; 18 for STEP_BITS=2).
- Divide by zero: done_o at cycle 1; div_zero_o = 1; quotient = all ones; remainder = dividend_i unmodified.
- Signed overflow: most-negative / -1 gives quotient = most-negative (wrap), remainder = 0, div_zero_o = 0.
- Unsigned mode: operands are never negated; no sign fix-up.
- flush_i: has priority over everything. From any state, the next edge goes to IDLE with done_o = 0 and hilo_o unchanged. A start_i in the same cycle as flush_i is ignored.
- stallreq_o is low in DONE, so the execute stage advances that cycle. A start_i seen in IDLE the following cycle is treated as a new instruction.
- Operand changes on dividend_i/divisor_i/signed_i after sampling have no effect.
- start_i deasserted mid-operation (without flush) does not abort; the result still completes and is strobed.
- div_zero_o is cleared when a new operation starts.
- hilo_o updates only on entry to DONE.

Test Plan:
- WIDTH=32, STEP_BITS=1, unsigned 100/7 -> done_o at cycle 34; hilo_o = {0x00000002, 0x0000000E}; stallreq_o high cycles 0-33, low in 34.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0, dividend 0x12345678 -> done_o at cycle 1; div_zero_o = 1; hilo_o = {0x12345678, 0xFFFFFFFF}.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned same operands -> quotient 0, remainder 0x80000000.
- flush_i pulsed at cycle 10 of a divide -> IDLE at cycle 11; no done_o; hilo_o keeps the previous result. New start at cycle 12 completes normally at cycle 46.
- STEP_BITS=2, unsigned 0xFFFFFFFF/3 -> done_o at cycle 18; quotient 0x55555555, remainder 0. rst_n low mid-CALC -> immediate IDLE with all outputs 0.
